// File: rtl/glitcbus_pkg.sv
// Shared definitions for the GLITCBUS register arbiter: internal-master FSM
// encodings, default decode parameters and statistics-word offsets.
package glitcbus_pkg;

    typedef enum logic [1:0] {
        IM_IDLE  = 2'd0,
        IM_ISSUE = 2'd1,
        IM_ACK   = 2'd2
    } im_state_t;

    localparam int          DEF_SEL_LSB        = 12;
    localparam logic [31:0] DEF_UNMAPPED_VALUE = 32'hDEADBEEF;
    localparam logic [15:0] DEF_STATS_BASE     = 16'hFFF0;

    // Word offsets from the statistics base; the last one is the clear register.
    localparam logic [1:0] STATS_OFS_EXT   = 2'd0;
    localparam logic [1:0] STATS_OFS_IM    = 2'd1;
    localparam logic [1:0] STATS_OFS_RETRY = 2'd2;
    localparam logic [1:0] STATS_OFS_CLR   = 2'd3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/glitcbus_reg_decode.sv
// Block index to one-hot select and read-data mux; indices at or above NSLAVE
// select nothing and return the unmapped pattern.
module glitcbus_reg_decode
    import glitcbus_pkg::*;
#(
    parameter int          NSLAVE         = 4,
    parameter logic [31:0] UNMAPPED_VALUE = DEF_UNMAPPED_VALUE
) (
    input  logic [2:0]           blk_idx,
    input  logic [32*NSLAVE-1:0] reg_dat_i,
    output logic [NSLAVE-1:0]    blk_sel,
    output logic [31:0]          blk_rdata
);

    always_comb begin
        blk_sel   = '0;
        blk_rdata = UNMAPPED_VALUE;
        for (int k = 0; k < NSLAVE; k++) begin
            if (blk_idx == 3'(k)) begin
                blk_sel[k] = 1'b1;
                blk_rdata  = reg_dat_i[32*k +: 32];
            end
        end
    end

endmodule

// File: rtl/glitcbus_reg_arbiter.sv
// Arbitrates the GLITCBUS register space between zero-wait external strobes and
// an internal req/ack master. Optional statistics: GLITCBUS_REG_ARBITER_STATS_EN.
module glitcbus_reg_arbiter
    import glitcbus_pkg::*;
#(
    parameter int          NSLAVE         = 4,
    parameter int          SEL_LSB        = DEF_SEL_LSB,
    parameter logic [31:0] UNMAPPED_VALUE = DEF_UNMAPPED_VALUE,
    parameter logic [15:0] STATS_BASE     = DEF_STATS_BASE
) (
    input  logic                  gclk_i,
    input  logic                  rst_i,
    input  logic [15:0]           gb_adr_i,
    input  logic [31:0]           gb_dat_i,
    input  logic                  gb_rd_i,
    input  logic                  gb_wr_i,
    output logic [31:0]           gb_dat_o,
    input  logic                  im_req_i,
    input  logic                  im_wr_i,
    input  logic [15:0]           im_adr_i,
    input  logic [31:0]           im_dat_i,
    output logic                  im_ack_o,
    output logic [31:0]           im_dat_o,
    output logic [15:0]           reg_adr_o,
    output logic [31:0]           reg_dat_o,
    output logic [NSLAVE-1:0]     reg_rd_o,
    output logic [NSLAVE-1:0]     reg_wr_o,
    input  logic [32*NSLAVE-1:0]  reg_dat_i,
    output logic                  reg_owner_o,
    output logic [7:0]            debug_o
);

    im_state_t          state_q, state_d;
    logic [15:0]        im_adr_q;
    logic [31:0]        im_dat_q;
    logic               im_wr_q;
    logic               ext_active, im_issue, retry_pending;
    logic [15:0]        cur_adr;
    logic [2:0]         blk_idx;
    logic               rd_strobe, wr_strobe, stats_hit;
    logic [NSLAVE-1:0]  blk_sel;
    logic [31:0]        blk_rdata, stats_rdata, rd_data;

    // Internal handshake: im_req_i is sampled only in IM_IDLE, where the
    // address, data and direction are captured; the request may drop right
    // after. Exactly one im_ack_o pulse follows per accepted request, two
    // cycles later, or three if an external strobe forced a retry.
    assign ext_active = gb_rd_i | gb_wr_i;
    assign cur_adr    = ext_active ? gb_adr_i : im_adr_q;
    assign blk_idx    = cur_adr[SEL_LSB+2:SEL_LSB];

    glitcbus_reg_decode #(
        .NSLAVE         (NSLAVE),
        .UNMAPPED_VALUE (UNMAPPED_VALUE)
    ) u_decode (
        .blk_idx   (blk_idx),
        .reg_dat_i (reg_dat_i),
        .blk_sel   (blk_sel),
        .blk_rdata (blk_rdata)
    );

    always_comb begin
        state_d       = state_q;
        im_issue      = 1'b0;
        retry_pending = 1'b0;
        case (state_q)
            IM_IDLE: begin
                if (im_req_i) state_d = IM_ISSUE;
            end
            IM_ISSUE: begin
                // The slave samples read data in its strobe cycle, so it never waits.
                if (ext_active) begin
                    retry_pending = 1'b1;
                end else begin
                    im_issue = 1'b1;
                    state_d  = IM_ACK;
                end
            end
            IM_ACK:  state_d = IM_IDLE;
            default: state_d = IM_IDLE;
        endcase
    end

    always_ff @(posedge gclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IM_IDLE;
            im_adr_q <= '0;
            im_dat_q <= '0;
            im_wr_q  <= 1'b0;
            im_dat_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IM_IDLE && im_req_i) begin
                im_adr_q <= im_adr_i;
                im_dat_q <= im_dat_i;
                im_wr_q  <= im_wr_i;
            end
            if (im_issue && !im_wr_q) im_dat_o <= rd_data;
        end
    end

    // A simultaneous external read and write is treated as a write only.
    assign rd_strobe = ext_active ? (gb_rd_i & ~gb_wr_i) : (im_issue & ~im_wr_q);
    assign wr_strobe = ext_active ? gb_wr_i : (im_issue & im_wr_q);

    assign reg_rd_o    = (rd_strobe && !stats_hit) ? blk_sel : '0;
    assign reg_wr_o    = (wr_strobe && !stats_hit) ? blk_sel : '0;
    assign reg_adr_o   = cur_adr;
    assign reg_dat_o   = ext_active ? gb_dat_i : im_dat_q;
    assign reg_owner_o = im_issue;
    assign rd_data     = stats_hit ? stats_rdata : blk_rdata;
    assign gb_dat_o    = rd_data;
    assign im_ack_o    = (state_q == IM_ACK);
    assign debug_o     = {state_q, retry_pending, reg_owner_o, blk_idx, ext_active};

`ifdef GLITCBUS_REG_ARBITER_STATS_EN
    localparam bit STATS_EN = 1'b1;

    logic [15:0] ext_count, im_count, retry_count;
    logic        stats_clr;

    assign stats_clr = stats_hit && wr_strobe && (cur_adr[1:0] == STATS_OFS_CLR);

    // Clear has priority, so an increment in the same cycle is dropped.
    always_ff @(posedge gclk_i or posedge rst_i) begin
        if (rst_i) begin
            ext_count   <= '0;
            im_count    <= '0;
            retry_count <= '0;
        end else if (stats_clr) begin
            ext_count   <= '0;
            im_count    <= '0;
            retry_count <= '0;
        end else begin
            if (ext_active)    ext_count   <= sat_inc(ext_count);
            if (im_ack_o)      im_count    <= sat_inc(im_count);
            if (retry_pending) retry_count <= sat_inc(retry_count);
        end
    end

    always_comb begin
        stats_rdata = '0;
        case (cur_adr[1:0])
            STATS_OFS_EXT:   stats_rdata = {16'h0000, ext_count};
            STATS_OFS_IM:    stats_rdata = {16'h0000, im_count};
            STATS_OFS_RETRY: stats_rdata = {16'h0000, retry_count};
            default:         stats_rdata = '0;
        endcase
    end
`else
    localparam bit STATS_EN = 1'b0;

    assign stats_rdata = '0;
`endif

    // The statistics window is four words on a 4-aligned base.
    assign stats_hit = STATS_EN && (cur_adr[15:2] == STATS_BASE[15:2]);

endmodule

// File: tb/tb_glitcbus_reg_arbiter.sv
// Randomized self-checking bench for glitcbus_reg_arbiter (default build).
`timescale 1ns/1ps
module tb_glitcbus_reg_arbiter;

    localparam int          NSLAVE   = 4;
    localparam logic [31:0] UNMAPPED = 32'hDEADBEEF;

    logic                  gclk_i = 1'b0;
    logic                  rst_i;
    logic [15:0]           gb_adr_i;
    logic [31:0]           gb_dat_i;
    logic                  gb_rd_i, gb_wr_i;
    logic [31:0]           gb_dat_o;
    logic                  im_req_i, im_wr_i;
    logic [15:0]           im_adr_i;
    logic [31:0]           im_dat_i;
    logic                  im_ack_o;
    logic [31:0]           im_dat_o;
    logic [15:0]           reg_adr_o;
    logic [31:0]           reg_dat_o;
    logic [NSLAVE-1:0]     reg_rd_o, reg_wr_o;
    logic [32*NSLAVE-1:0]  reg_dat_i;
    logic                  reg_owner_o;
    logic [7:0]            debug_o;

    logic [31:0]           slave_data [NSLAVE];
    logic [31:0]           exp_q [$];
    logic [31:0]           im_dat_exp;
    int                    n_tests = 0;
    int                    n_fail  = 0;

    for (genvar k = 0; k < NSLAVE; k++) begin : g_slave
        assign reg_dat_i[32*k +: 32] = slave_data[k];
    end

    glitcbus_reg_arbiter #(.NSLAVE(NSLAVE)) dut (
        .gclk_i      (gclk_i),
        .rst_i       (rst_i),
        .gb_adr_i    (gb_adr_i),
        .gb_dat_i    (gb_dat_i),
        .gb_rd_i     (gb_rd_i),
        .gb_wr_i     (gb_wr_i),
        .gb_dat_o    (gb_dat_o),
        .im_req_i    (im_req_i),
        .im_wr_i     (im_wr_i),
        .im_adr_i    (im_adr_i),
        .im_dat_i    (im_dat_i),
        .im_ack_o    (im_ack_o),
        .im_dat_o    (im_dat_o),
        .reg_adr_o   (reg_adr_o),
        .reg_dat_o   (reg_dat_o),
        .reg_rd_o    (reg_rd_o),
        .reg_wr_o    (reg_wr_o),
        .reg_dat_i   (reg_dat_i),
        .reg_owner_o (reg_owner_o),
        .debug_o     (debug_o)
    );

    // ---------------- clock / reset ----------------
    always #5 gclk_i = ~gclk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int blk_of(input logic [15:0] a);
        return int'((a >> 12) & 16'd7);
    endfunction

    function automatic logic [NSLAVE-1:0] exp_sel(input logic [15:0] a);
        int b = blk_of(a);
        return (b < NSLAVE) ? (NSLAVE'(1) << b) : '0;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [15:0] a);
        int b = blk_of(a);
        return (b < NSLAVE) ? slave_data[b] : UNMAPPED;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge gclk_i);
        #1;
    endtask

    task automatic idle_inputs();
        gb_rd_i  = 1'b0;
        gb_wr_i  = 1'b0;
        im_req_i = 1'b0;
    endtask

    task automatic randomize_slaves();
        for (int k = 0; k < NSLAVE; k++) slave_data[k] = $urandom;
    endtask

    // One internal access, optionally with an external write at cycle coll
    // (cycle 0 = request cycle). Records observations over 8 cycles.
    task automatic run_im(input logic wr, input logic [15:0] adr, input logic [31:0] dat,
                          input int coll, input logic [15:0] eadr,
                          output int ack_cyc, output int n_acks, output int n_own, output int own_cyc,
                          output logic [NSLAVE-1:0] own_rd, output logic [NSLAVE-1:0] own_wr,
                          output logic retry_seen, output logic [NSLAVE-1:0] ext_wr_seen,
                          output logic ext_owner_seen);
        ack_cyc = -1; n_acks = 0; n_own = 0; own_cyc = -1;
        own_rd = '0; own_wr = '0; retry_seen = 1'b0; ext_wr_seen = '0; ext_owner_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            im_req_i = (c == 0);
            im_wr_i  = wr;
            im_adr_i = adr;
            im_dat_i = dat;
            gb_rd_i  = 1'b0;
            gb_wr_i  = (c == coll);
            gb_adr_i = eadr;
            gb_dat_i = ~dat;
            @(negedge gclk_i);
            if (reg_owner_o) begin
                n_own++;
                own_cyc = c;
                own_rd  = reg_rd_o;
                own_wr  = reg_wr_o;
            end
            if (debug_o[5]) retry_seen = 1'b1;
            if (c == coll) begin
                ext_wr_seen    = reg_wr_o;
                ext_owner_seen = reg_owner_o;
            end
            if (im_ack_o) begin
                n_acks++;
                if (ack_cyc < 0) ack_cyc = c;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        gb_adr_i = '0; gb_dat_i = '0; im_wr_i = 1'b0; im_adr_i = '0; im_dat_i = '0;
        randomize_slaves();
        repeat (2) @(posedge gclk_i);
        @(negedge gclk_i);
        n_tests++; if (im_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b want 0", im_ack_o); end
        n_tests++; if (im_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_im_dat: got %h want 0", im_dat_o); end
        n_tests++; if ({reg_rd_o, reg_wr_o, reg_owner_o} !== '0) begin n_fail++; $display("FAIL reset_strobes: rd %b wr %b own %b want 0", reg_rd_o, reg_wr_o, reg_owner_o); end
        n_tests++; if (debug_o !== 8'h00) begin n_fail++; $display("FAIL reset_debug: got %h want 00", debug_o); end
        n_tests++; if ({reg_adr_o, reg_dat_o} !== '0) begin n_fail++; $display("FAIL reset_reg_bus: adr %h dat %h want 0", reg_adr_o, reg_dat_o); end
        n_tests++; if (gb_dat_o !== exp_rdata(16'h0000)) begin n_fail++; $display("FAIL reset_gb_dat: got %h want %h", gb_dat_o, exp_rdata(16'h0000)); end
        @(posedge gclk_i);
        #1 rst_i = 1'b0;
        im_dat_exp = 32'h0;
    endtask

    task automatic test_ext_read_fixed();
        slave_data[1] = 32'hCAFE0001;
        gb_adr_i = 16'h1004; gb_rd_i = 1'b1;
        @(negedge gclk_i);
        n_tests++; if (reg_rd_o !== 4'b0010) begin n_fail++; $display("FAIL ext_fixed_rd: got %b want 0010", reg_rd_o); end
        n_tests++; if (gb_dat_o !== 32'hCAFE0001) begin n_fail++; $display("FAIL ext_fixed_dat: got %h want cafe0001", gb_dat_o); end
        n_tests++; if ({reg_owner_o, reg_wr_o} !== '0) begin n_fail++; $display("FAIL ext_fixed_own: own %b wr %b want 0", reg_owner_o, reg_wr_o); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_ext_random();
        logic [15:0] a; logic [31:0] d; int mode;
        logic [NSLAVE-1:0] e_rd, e_wr;
        for (int i = 0; i < 24; i++) begin
            randomize_slaves();
            a = 16'($urandom_range(0, 16'hFFFF));
            d = $urandom;
            mode = $urandom_range(0, 2);
            gb_adr_i = a; gb_dat_i = d;
            gb_rd_i = (mode != 1); gb_wr_i = (mode != 0);
            e_rd = (mode == 0) ? exp_sel(a) : '0;
            e_wr = (mode != 0) ? exp_sel(a) : '0;
            @(negedge gclk_i);
            n_tests++; if ({reg_rd_o, reg_wr_o, reg_owner_o} !== {e_rd, e_wr, 1'b0}) begin
                n_fail++; $display("FAIL ext_rand_strobes[%0d]: rd %b wr %b own %b want %b %b 0", i, reg_rd_o, reg_wr_o, reg_owner_o, e_rd, e_wr);
            end
            n_tests++; if (gb_dat_o !== exp_rdata(a)) begin n_fail++; $display("FAIL ext_rand_dat[%0d]: got %h want %h", i, gb_dat_o, exp_rdata(a)); end
            n_tests++; if ({reg_adr_o, reg_dat_o} !== {a, d}) begin n_fail++; $display("FAIL ext_rand_bus[%0d]: adr %h dat %h want %h %h", i, reg_adr_o, reg_dat_o, a, d); end
            next_cycle();
            idle_inputs();
        end
    endtask

    task automatic test_im_write();
        int ack_cyc, n_acks, n_own, own_cyc;
        logic [NSLAVE-1:0] own_rd, own_wr, ext_wr_seen; logic retry_seen, ext_own;
        run_im(1'b1, 16'h2010, 32'h12345678, -1, 16'h0000,
               ack_cyc, n_acks, n_own, own_cyc, own_rd, own_wr, retry_seen, ext_wr_seen, ext_own);
        n_tests++; if ({n_own, own_cyc} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL im_wr_issue: count %0d cycle %0d want 1 1", n_own, own_cyc); end
        n_tests++; if ({own_wr, own_rd} !== {4'b0100, 4'b0000}) begin n_fail++; $display("FAIL im_wr_sel: wr %b rd %b want 0100 0000", own_wr, own_rd); end
        n_tests++; if ({n_acks, ack_cyc} !== {32'd1, 32'd2}) begin n_fail++; $display("FAIL im_wr_ack: count %0d cycle %0d want 1 2", n_acks, ack_cyc); end
        @(negedge gclk_i);
        n_tests++; if ({reg_adr_o, reg_dat_o, reg_rd_o, reg_wr_o} !== {16'h2010, 32'h12345678, 8'h00}) begin
            n_fail++; $display("FAIL im_wr_hold: adr %h dat %h rd %b wr %b want 2010 12345678 0 0", reg_adr_o, reg_dat_o, reg_rd_o, reg_wr_o);
        end
        n_tests++; if (im_dat_o !== im_dat_exp) begin n_fail++; $display("FAIL im_wr_dat_kept: got %h want %h", im_dat_o, im_dat_exp); end
        next_cycle();
    endtask

    task automatic test_im_read_retry();
        int ack_cyc, n_acks, n_own, own_cyc;
        logic [NSLAVE-1:0] own_rd, own_wr, ext_wr_seen; logic retry_seen, ext_own;
        randomize_slaves();
        run_im(1'b0, 16'h3008, 32'h0, 1, 16'h0000,
               ack_cyc, n_acks, n_own, own_cyc, own_rd, own_wr, retry_seen, ext_wr_seen, ext_own);
        im_dat_exp = slave_data[3];
        n_tests++; if ({ext_wr_seen, ext_own} !== {4'b0001, 1'b0}) begin n_fail++; $display("FAIL retry_ext_pass: wr %b own %b want 0001 0", ext_wr_seen, ext_own); end
        n_tests++; if (retry_seen !== 1'b1) begin n_fail++; $display("FAIL retry_flag: got %b want 1", retry_seen); end
        n_tests++; if ({own_cyc, own_rd} !== {32'd2, 4'b1000}) begin n_fail++; $display("FAIL retry_issue: cycle %0d rd %b want 2 1000", own_cyc, own_rd); end
        n_tests++; if ({n_acks, ack_cyc} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL retry_ack: count %0d cycle %0d want 1 3", n_acks, ack_cyc); end
        n_tests++; if (im_dat_o !== im_dat_exp) begin n_fail++; $display("FAIL retry_dat: got %h want %h", im_dat_o, im_dat_exp); end
    endtask

    task automatic test_unmapped();
        int ack_cyc, n_acks, n_own, own_cyc;
        logic [NSLAVE-1:0] own_rd, own_wr, ext_wr_seen; logic retry_seen, ext_own;
        gb_adr_i = 16'h7000; gb_rd_i = 1'b1;
        @(negedge gclk_i);
        n_tests++; if ({reg_rd_o, reg_wr_o} !== 8'h00) begin n_fail++; $display("FAIL unmapped_ext_strobe: rd %b wr %b want 0", reg_rd_o, reg_wr_o); end
        n_tests++; if (gb_dat_o !== UNMAPPED) begin n_fail++; $display("FAIL unmapped_ext_dat: got %h want %h", gb_dat_o, UNMAPPED); end
        next_cycle();
        idle_inputs();
        run_im(1'b0, 16'h7000, 32'h0, -1, 16'h0000,
               ack_cyc, n_acks, n_own, own_cyc, own_rd, own_wr, retry_seen, ext_wr_seen, ext_own);
        im_dat_exp = UNMAPPED;
        n_tests++; if ({own_rd, own_wr} !== 8'h00) begin n_fail++; $display("FAIL unmapped_im_strobe: rd %b wr %b want 0", own_rd, own_wr); end
        n_tests++; if (ack_cyc !== 2) begin n_fail++; $display("FAIL unmapped_im_ack: cycle %0d want 2", ack_cyc); end
        n_tests++; if (im_dat_o !== UNMAPPED) begin n_fail++; $display("FAIL unmapped_im_dat: got %h want %h", im_dat_o, UNMAPPED); end
    endtask

    task automatic test_reset_mid();
        int acks;
        im_req_i = 1'b1; im_wr_i = 1'b1; im_adr_i = 16'h1000; im_dat_i = 32'hA5A5A5A5;
        next_cycle();
        im_req_i = 1'b0;
        @(negedge gclk_i);
        n_tests++; if ({reg_wr_o, reg_owner_o} !== {4'b0010, 1'b1}) begin n_fail++; $display("FAIL rstmid_pre: wr %b own %b want 0010 1", reg_wr_o, reg_owner_o); end
        rst_i = 1'b1;
        #1;
        n_tests++; if ({reg_rd_o, reg_wr_o, reg_owner_o} !== '0) begin n_fail++; $display("FAIL rstmid_drop: rd %b wr %b own %b want 0", reg_rd_o, reg_wr_o, reg_owner_o); end
        @(posedge gclk_i);
        #1 rst_i = 1'b0;
        im_dat_exp = 32'h0;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge gclk_i);
            if (im_ack_o) acks++;
            next_cycle();
        end
        n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d acks want 0", acks); end
        @(negedge gclk_i);
        n_tests++; if (debug_o[7:6] !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle: state %b want 00", debug_o[7:6]); end
        n_tests++; if (im_dat_o !== im_dat_exp) begin n_fail++; $display("FAIL rstmid_dat: got %h want %h", im_dat_o, im_dat_exp); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [9:0] got_acks, exp_acks;
        int next_free;
        got_acks = '0; exp_acks = '0; next_free = 0;
        // Requests are only taken when idle; each takes three cycles end to end.
        for (int c = 0; c < 10; c++) begin
            if (c < 6 && c >= next_free) begin
                exp_acks[c+2] = 1'b1;
                next_free = c + 3;
            end
        end
        for (int c = 0; c < 10; c++) begin
            im_req_i = (c < 6); im_wr_i = 1'b0; im_adr_i = 16'h0010;
            @(negedge gclk_i);
            got_acks[c] = im_ack_o;
            next_cycle();
        end
        idle_inputs();
        im_dat_exp = slave_data[0];
        n_tests++; if (got_acks !== exp_acks) begin n_fail++; $display("FAIL b2b_acks: got %b want %b", got_acks, exp_acks); end
        n_tests++; if (im_dat_o !== im_dat_exp) begin n_fail++; $display("FAIL b2b_dat: got %h want %h", im_dat_o, im_dat_exp); end
    endtask

    task automatic test_im_random();
        int ack_cyc, n_acks, n_own, own_cyc, coll, exp_issue;
        logic [NSLAVE-1:0] own_rd, own_wr, ext_wr_seen; logic retry_seen, ext_own;
        logic wr; logic [15:0] a, ea; logic [31:0] d, e_dat;
        for (int i = 0; i < 16; i++) begin
            randomize_slaves();
            wr   = 1'($urandom_range(0, 1));
            a    = 16'($urandom_range(0, 16'hFFFF));
            ea   = 16'($urandom_range(0, 16'hFFFF));
            d    = $urandom;
            coll = $urandom_range(0, 3) - 1;
            exp_issue = (coll == 1) ? 2 : 1;
            if (!wr) exp_q.push_back(exp_rdata(a));
            run_im(wr, a, d, coll, ea,
                   ack_cyc, n_acks, n_own, own_cyc, own_rd, own_wr, retry_seen, ext_wr_seen, ext_own);
            n_tests++; if ({n_own, own_cyc} !== {32'd1, exp_issue}) begin n_fail++; $display("FAIL rand_issue[%0d]: count %0d cycle %0d want 1 %0d", i, n_own, own_cyc, exp_issue); end
            n_tests++; if ({own_rd, own_wr} !== (wr ? {4'b0000, exp_sel(a)} : {exp_sel(a), 4'b0000})) begin
                n_fail++; $display("FAIL rand_sel[%0d]: rd %b wr %b adr %h wr_dir %b", i, own_rd, own_wr, a, wr);
            end
            n_tests++; if ({n_acks, ack_cyc} !== {32'd1, exp_issue + 1}) begin n_fail++; $display("FAIL rand_ack[%0d]: count %0d cycle %0d want 1 %0d", i, n_acks, ack_cyc, exp_issue + 1); end
            n_tests++; if (retry_seen !== (coll == 1)) begin n_fail++; $display("FAIL rand_retry[%0d]: got %b coll %0d", i, retry_seen, coll); end
            if (coll >= 0) begin
                n_tests++; if ({ext_wr_seen, ext_own} !== {exp_sel(ea), 1'b0}) begin
                    n_fail++; $display("FAIL rand_ext_pass[%0d]: wr %b own %b want %b 0", i, ext_wr_seen, ext_own, exp_sel(ea));
                end
            end
            if (!wr && exp_q.size() > 0) begin
                e_dat = exp_q.pop_front();
                im_dat_exp = e_dat;
            end
            n_tests++; if (im_dat_o !== im_dat_exp) begin n_fail++; $display("FAIL rand_dat[%0d]: got %h want %h", i, im_dat_o, im_dat_exp); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ext_read_fixed();
        test_ext_random();
        test_im_write();
        test_im_read_retry();
        test_unmapped();
        test_back_to_back();
        test_im_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/glitcbus_reg_arbiter.md
Name: glitcbus_reg_arbiter

Overview:
- Shares the GLITCBUS register space between two masters: the GLITCBUS slave's one-cycle rd/wr strobes, and an internal master (local sequencer / control logic) using a req/ack handshake.
- Decodes the 16-bit address into NSLAVE register-block selects and muxes their read data back.
- Sits between glitcbus_slave_v2 and the per-block register files.
- The external path always has zero-wait-state priority, because the slave samples read data in the same cycle it strobes.

Parameters:
- NSLAVE, 4: number of downstream register blocks (1..8).
- SEL_LSB, 12: block index = adr[SEL_LSB+2:SEL_LSB].
- UNMAPPED_VALUE, 32'hDEADBEEF: read data returned for unmapped addresses.
- STATS_BASE, 16'hFFF0: base address of the statistics words (only with the optional feature).

Ports:
- gclk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- gb_adr_i  in  16  external address (valid while gb_rd_i/gb_wr_i is high).
- gb_dat_i  in  32  external write data.
- gb_rd_i  in  1  external read strobe, one cycle.
- gb_wr_i  in  1  external write strobe, one cycle.
- gb_dat_o  out  32  external read data, combinational in the strobe cycle.
- im_req_i  in  1  internal request.
- im_wr_i  in  1  internal direction: 1 = write, 0 = read.
- im_adr_i  in  16  internal address.
- im_dat_i  in  32  internal write data.
- im_ack_o  out  1  internal completion pulse.
- im_dat_o  out  32  internal read data, registered.
- reg_adr_o  out  16  downstream address.
- reg_dat_o  out  32  downstream write data.
- reg_rd_o  out  NSLAVE  one-hot read strobe.
- reg_wr_o  out  NSLAVE  one-hot write strobe.
- reg_dat_i  in  32*NSLAVE  downstream read data, combinational, slave k at [32k +: 32].
- reg_owner_o  out  1  0 = external, 1 = internal.
- debug_o  out  8  {im_state[1:0], retry_pending, reg_owner_o, blk_idx[2:0], ext_active}.

Behaviour:
- Reset values: all outputs 0, except gb_dat_o, which follows the combinational mux.
  - im_dat_o = 0, im_ack_o = 0, FSM = IM_IDLE.
  - Reset mid-operation drops any in-flight internal access; no ack is issued.
- External path, fully combinational:
  - When gb_rd_i or gb_wr_i is high: reg_adr_o = gb_adr_i, reg_dat_o = gb_dat_i, reg_owner_o = 0.
  - The selected reg_rd_o/reg_wr_o bit equals the strobe.
  - gb_dat_o = reg_dat_i of the selected block, or UNMAPPED_VALUE if the index ≥ NSLAVE.
  - gb_rd_i and gb_wr_i both high: treat as write only; reg_rd_o is all 0.
- Internal FSM:
  - IM_IDLE: on im_req_i, latch im_adr_i/im_dat_i/im_wr_i → IM_ISSUE.
  - IM_ISSUE, external strobe high this cycle: the external access wins. Internal strobes stay 0, retry_pending = 1, stay in IM_ISSUE.
  - IM_ISSUE, no external strobe: drive downstream from the latched registers with reg_owner_o = 1 and a one-cycle strobe. On a read, capture the muxed data (or UNMAPPED_VALUE) into im_dat_o → IM_ACK.
  - IM_ACK: im_ack_o = 1 for exactly one cycle → IM_IDLE.
- Handshake rules:
  - Minimum latency from req to ack is 2 cycles (req seen in IDLE, issue, ack).
  - External strobes are spaced ≥6 cycles apart, so at most 1 retry occurs and worst-case latency is 3 cycles.
  - Dropping im_req_i after latching does not cancel the access; ack still pulses.
  - im_req_i still high in the IM_ACK cycle is ignored; a new request is accepted from IM_IDLE only.
- im_dat_o holds its value until the next internal read completes; internal writes leave it unchanged.
- When idle, reg_* outputs hold the last internal latched values with strobes at 0.

Optional Feature:
- Macro: GLITCBUS_REG_ARBITER_STATS_EN.
- With the macro defined:
  - Three 16-bit saturating counters: ext_count (external strobes), im_count (internal completions), retry_count (IM_ISSUE stalls).
  - Read at STATS_BASE+0/1/2 with value zero-extended; this decode overrides block decode for both masters.
  - Any write to STATS_BASE+3 clears all three counters. A same-cycle increment is lost, and the clear wins.
  - Counters saturate at 16'hFFFF.
- Without the macro: no counters; STATS_BASE addresses decode normally.

Decomposition:
- Shared package glitcbus_pkg holds:
  - the IM_* state encodings;
  - the defaults for SEL_LSB and UNMAPPED_VALUE;
  - the STATS_BASE offsets.
- One natural sub-module: glitcbus_reg_decode, a combinational address → one-hot select and read-data mux, instanced once.

Test Plan:
- External read at 16'h1004, reg_dat_i block1 = 32'hCAFE0001 → reg_rd_o = 4'b0010 in the same cycle, gb_dat_o = 32'hCAFE0001, reg_owner_o = 0.
- Internal write adr 16'h2010, data 32'h12345678, no external traffic → reg_wr_o = 4'b0100 exactly once, 1 cycle after req; im_ack_o pulses on cycle 2.
- Internal read issued in the same cycle as an external write to 16'h0000 → external strobe passes, internal stalls 1 cycle (retry_pending = 1), then completes; im_dat_o is correct and ack comes at cycle 3.
- Read at 16'h7000 with NSLAVE = 4 from both masters → all strobes 0; both return 32'hDEADBEEF.
- rst_i asserted while in IM_ISSUE → all strobes drop immediately; no im_ack_o; FSM in IM_IDLE after release.
- With GLITCBUS_REG_ARBITER_STATS_EN:
  - Perform 3 external and 2 internal accesses with 1 retry → reads of STATS_BASE+0/1/2 return 3/2/1. Issue these reads from the internal master, because external reads of the statistics words increment ext_count.
  - Write to STATS_BASE+3 → all three counters return 0.
